fp_mac_sequencer: RTL

FP_MAC_SEQUENCER -- requirements
Module: fp_mac_sequencer

---
 rtl/fp_mac_pkg.sv | 17 +
 rtl/mac_lat_counter.sv | 29 ++
 rtl/fp_mac_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/fp_mac_pkg.sv
// Shared definitions for the floating-point MAC job sequencer: state encoding,
// datapath latency default and field widths.
package fp_mac_pkg;

  localparam int PIPE_LAT_DEFAULT = 3;
  localparam int LAT_W            = 4;   // holds PIPE_LAT-1 for PIPE_LAT up to 15
  localparam int LEN_W            = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

endpackage

// File: rtl/mac_lat_counter.sv
// Latency down-counter: loads the remaining writeback latency on each issue,
// counts down while the sequencer waits, and flags zero.
module mac_lat_counter
  import fp_mac_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [LAT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (i_dec && (r_cnt != '0))
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fp_mac_sequencer.sv
// Job controller for a pipelined MAC datapath: clears the accumulator, issues
// one operand pair per PIPE_LAT+1 cycles, and holds the result until consumed.
module fp_mac_sequencer
  import fp_mac_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             op_valid,
  output logic             op_ready,
  output logic             dp_acc_clr,
  output logic             dp_issue,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic [LEN_W-1:0] count
);

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic             w_run;
  logic             w_fire;
  logic             w_lat_zero;

  // Reset and abort both kill this cycle's handshakes before the state changes.
  assign w_run  = !reset && !abort;
  assign w_fire = (r_state == ST_ISSUE) && op_valid && w_run;

  always_ff @(posedge clock) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // NOTE: each combinational process assigns defaults first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (start) w_next = ST_CLEAR;
        ST_CLEAR:  w_next = (r_len == '0) ? ST_RESULT : ST_ISSUE;
        ST_ISSUE:  if (op_valid) w_next = ST_WAIT;
        ST_WAIT:   if (w_lat_zero) w_next = (r_count == r_len) ? ST_RESULT : ST_ISSUE;
        ST_RESULT: if (res_ready) w_next = ST_IDLE;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    op_ready   = 1'b0;
    dp_issue   = 1'b0;
    dp_acc_clr = 1'b0;
    res_valid  = 1'b0;
    case (r_state)
      ST_CLEAR:  dp_acc_clr = w_run;
      ST_ISSUE: begin
        op_ready = w_run;
        dp_issue = w_fire;
      end
      ST_RESULT: res_valid = w_run;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_len   <= '0;
      r_count <= '0;
    end else if ((r_state == ST_IDLE) && start && !abort) begin
      r_len   <= len;
      r_count <= '0;
    end else if (w_fire && (r_count < r_len)) begin
      r_count <= r_count + 1'b1;
    end
  end

  mac_lat_counter u_lat (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_fire),
    .i_load_val (LAT_W'(PIPE_LAT - 1)),
    .i_dec      (r_state == ST_WAIT),
    .o_zero     (w_lat_zero)
  );

  assign busy  = (r_state != ST_IDLE);
  assign count = r_count;

endmodule
